// File: rtl/mmio_responder.sv
// mmio_responder: word-wide bus responder for the processor core.
// Serves reads/writes to a local RAM and decodes two special addresses:
// a display register feeding the seven-segment driver, and a switch port
// whose reads complete only after a debounced press/release of SW[17].
module mmio_responder #(
    parameter int                    WORD_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 10,
    parameter logic [ADDR_WIDTH-1:0] DISP_ADDR   = 10'h3FE,
    parameter logic [ADDR_WIDTH-1:0] SWITCH_ADDR = 10'h3FF,
    parameter int                    DEBOUNCE    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read_req,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [WORD_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  busy,
    input  logic                  write_req,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [WORD_WIDTH-1:0] write_data,
    output logic                  write_ack,
    input  logic [17:0]           SW,
    output logic [WORD_WIDTH-1:0] displaying
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE);

    typedef enum logic [2:0] {
        IDLE,
        RESP,
        SW_PRESS,
        SW_RELEASE,
        SW_RESP
    } state_t;

    state_t                state_reg;
    logic [WORD_WIDTH-1:0] ram [DEPTH];
    logic [WORD_WIDTH-1:0] ram_q_reg;
    logic [WORD_WIDTH-1:0] disp_reg;
    logic [WORD_WIDTH-1:0] bypass_data_reg;
    logic                  bypass_reg;
    logic [WORD_WIDTH-1:0] latch_reg;
    logic [WORD_WIDTH-1:0] hold_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [1:0][17:0]      sync_reg;
    logic [17:0]           swq;
    logic [WORD_WIDTH-1:0] sw_word;
    logic                  write_hit;

    assign swq       = sync_reg[1];
    assign sw_word   = {{(WORD_WIDTH-17){1'b0}}, swq[16:0]};
    // A same-cycle write to the address being read must be returned (write-first).
    assign write_hit = write_req && (write_addr == read_addr);

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], SW};
        end
    end

    // RAM with registered read port; the switch address is never stored.
    always_ff @(posedge clock) begin
        if (write_req && (write_addr != SWITCH_ADDR)) begin
            ram[write_addr] <= write_data;
        end
        ram_q_reg <= ram[read_addr];
    end

    // Control FSM: write ack, display register, read sequencing and debounce.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            write_ack       <= 1'b0;
            disp_reg        <= '0;
            count_reg       <= '0;
            bypass_reg      <= 1'b0;
            bypass_data_reg <= '0;
            latch_reg       <= '0;
            hold_reg        <= '0;
        end else begin
            write_ack <= write_req;
            if (write_req && (write_addr == DISP_ADDR)) begin
                disp_reg <= write_data;
            end
            case (state_reg)
                IDLE: begin
                    if (read_req) begin
                        if (read_addr == SWITCH_ADDR) begin
                            state_reg <= SW_PRESS;
                            count_reg <= '0;
                        end else begin
                            state_reg <= RESP;
                            // The RAM port returns pre-write data, so forwarded
                            // write data and the display register bypass it.
                            bypass_reg      <= write_hit || (read_addr == DISP_ADDR);
                            bypass_data_reg <= write_hit ? write_data : disp_reg;
                        end
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    hold_reg  <= read_data;
                end
                SW_PRESS: begin
                    if (count_reg == DEB_MAX) begin
                        latch_reg <= sw_word;
                        count_reg <= '0;
                        state_reg <= SW_RELEASE;
                    end else if (swq[17]) begin
                        count_reg <= count_reg + 1'b1;
                    end else begin
                        count_reg <= '0;
                    end
                end
                SW_RELEASE: begin
                    if (count_reg == DEB_MAX) begin
                        count_reg <= '0;
                        state_reg <= SW_RESP;
                    end else if (!swq[17]) begin
                        count_reg <= count_reg + 1'b1;
                    end else begin
                        count_reg <= '0;
                    end
                end
                SW_RESP: begin
                    state_reg <= IDLE;
                    hold_reg  <= latch_reg;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Output decode from state; read_data holds the last response when idle.
    always_comb begin
        read_data  = hold_reg;
        displaying = disp_reg;
        read_valid = (state_reg == RESP) || (state_reg == SW_RESP);
        busy       = (state_reg != IDLE);
        case (state_reg)
            RESP:       read_data  = bypass_reg ? bypass_data_reg : ram_q_reg;
            SW_RESP:    read_data  = latch_reg;
            SW_PRESS:   displaying = sw_word;
            SW_RELEASE: displaying = '0;
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Testbench for mmio_responder: directed scenarios plus randomized traffic.
// Stimulus pushes expected responses into queues; a negedge monitor pops
// and compares them against write_ack, busy, read_valid and read_data.
module tb_mmio_responder;

    localparam int          WW   = 32;
    localparam int          AW   = 10;
    localparam int          DEB  = 16;
    localparam logic [9:0]  DISP = 10'h3FE;
    localparam logic [9:0]  SWA  = 10'h3FF;
    localparam int          BIG  = 32'h7fffffff;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          read_req = 1'b0;
    logic [AW-1:0] read_addr = '0;
    logic [WW-1:0] read_data;
    logic          read_valid;
    logic          busy;
    logic          write_req = 1'b0;
    logic [AW-1:0] write_addr = '0;
    logic [WW-1:0] write_data = '0;
    logic          write_ack;
    logic [17:0]   SW = '0;
    logic [WW-1:0] displaying;

    mmio_responder #(
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW),
        .DISP_ADDR  (DISP),
        .SWITCH_ADDR(SWA),
        .DEBOUNCE   (DEB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .read_req  (read_req),
        .read_addr (read_addr),
        .read_data (read_data),
        .read_valid(read_valid),
        .busy      (busy),
        .write_req (write_req),
        .write_addr(write_addr),
        .write_data(write_data),
        .write_ack (write_ack),
        .SW        (SW),
        .displaying(displaying)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          start;
        int          due;
    } exp_t;

    exp_t        rq[$];
    int          ackq[$];
    int          skip_until = 0;
    logic [31:0] last_data = '0;
    logic [31:0] mem_model [1024];
    logic [31:0] disp_model = '0;
    int          checks = 0;
    int          passes = 0;
    bit          mon_ack;
    bit          mon_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compare every DUT output against the scoreboard each cycle.
    always @(negedge clock) begin
        if (cyc >= skip_until) begin
            mon_ack = (ackq.size() > 0) && (ackq[0] == cyc);
            if (mon_ack) void'(ackq.pop_front());
            check("write_ack", {31'b0, write_ack}, {31'b0, mon_ack});
            mon_busy = (rq.size() > 0) && (rq[0].start <= cyc) && (cyc <= rq[0].due);
            check("busy", {31'b0, busy}, {31'b0, mon_busy});
            if ((rq.size() > 0) && (rq[0].due == cyc)) begin
                check("read_valid", {31'b0, read_valid}, 32'd1);
                if (read_valid) check("read_data", read_data, rq[0].data);
                last_data = rq[0].data;
                void'(rq.pop_front());
            end else begin
                check("read_valid", {31'b0, read_valid}, 32'd0);
                check("read_data_hold", read_data, last_data);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One cycle of bus traffic; model applies the write before the read (write-first).
    task automatic issue(input bit wr, input logic [9:0] wa, input logic [31:0] wd,
                         input bit rd, input logic [9:0] ra, input bit accept);
        exp_t e;
        write_req  = wr;
        write_addr = wa;
        write_data = wd;
        read_req   = rd;
        read_addr  = ra;
        if (wr) begin
            ackq.push_back(cyc + 1);
            if (wa != SWA) mem_model[wa] = wd;
            if (wa == DISP) disp_model = wd;
        end
        if (rd && accept) begin
            e.data  = (ra == DISP) ? disp_model : mem_model[ra];
            e.start = cyc + 1;
            e.due   = cyc + 1;
            rq.push_back(e);
        end
        step();
        write_req = 1'b0;
        read_req  = 1'b0;
    endtask

    task automatic sw_read(input logic [16:0] val);
        exp_t e;
        e.data  = {15'b0, val};
        e.start = cyc + 1;
        e.due   = BIG;
        rq.push_back(e);
        read_req  = 1'b1;
        read_addr = SWA;
        step();
        read_req = 1'b0;
    endtask

    // Release SW[17]; the response follows two sync stages plus DEBOUNCE counts.
    task automatic release_switch();
        exp_t e;
        SW[17] = 1'b0;
        e = rq.pop_front();
        e.due = cyc + DEB + 3;
        rq.push_front(e);
    endtask

    task automatic press(input int n, input logic [31:0] exp_disp);
        SW[17] = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            if (i == 15) check("disp_press", displaying, exp_disp);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        rq.delete();
        ackq.delete();
        skip_until = cyc + 1;
        last_data  = '0;
        disp_model = '0;
        step();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_valid", {31'b0, read_valid}, 32'd0);
        check("rst_disp", displaying, 32'd0);
        step();
        reset = 1'b0;
    endtask

    logic [9:0] pool [12] = '{10'd0, 10'd1, 10'd2, 10'd5, 10'd7, 10'd8,
                              10'd100, 10'd511, 10'd512, 10'd1000, DISP, SWA};

    initial begin
        bit          prev_acc;
        bit          wr;
        bit          rd;
        bit          acc;
        reset_dut();

        // Basic write then read.
        issue(1, 10'd5, 32'h1234, 0, 10'd0, 0);
        issue(0, 10'd0, 32'h0, 1, 10'd5, 1);
        repeat (2) step();

        // Display register write and readback.
        issue(1, DISP, 32'd42, 0, 10'd0, 0);
        check("disp_write", displaying, 32'd42);
        issue(0, 10'd0, 32'h0, 1, DISP, 1);
        repeat (2) step();

        // Same-cycle read/write of addr 7, then a read while busy (ignored).
        issue(1, 10'd7, 32'h55, 1, 10'd7, 1);
        issue(0, 10'd0, 32'h0, 1, 10'd5, 0);
        repeat (2) step();

        // Full switch read with a display write during the press.
        SW = {1'b0, 17'h0ABC};
        repeat (3) step();
        sw_read(17'h0ABC);
        SW[17] = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i == 3) begin
                write_req = 1'b1; write_addr = DISP; write_data = 32'h77;
                ackq.push_back(cyc + 1);
                mem_model[DISP] = 32'h77;
                disp_model = 32'h77;
            end
            step();
            write_req = 1'b0;
            if (i == 15) check("disp_mirror", displaying, 32'h0ABC);
        end
        release_switch();
        for (int i = 0; i < 24; i++) begin
            step();
            if (i == 4) check("disp_release", displaying, 32'd0);
        end
        check("disp_after_sw", displaying, 32'h77);

        // Bounce on SW[17] must not latch; a full press afterwards must.
        SW = {1'b0, 17'h15A5A};
        repeat (3) step();
        sw_read(17'h15A5A);
        SW[17] = 1'b1;
        repeat (5) step();
        SW[17] = 1'b0;
        repeat (10) step();
        check("disp_bounce", displaying, 32'h15A5A);
        press(18, 32'h15A5A);
        release_switch();
        repeat (24) step();

        // Reset during SW_RELEASE aborts the read.
        SW = {1'b0, 17'h00123};
        repeat (3) step();
        sw_read(17'h00123);
        press(18, 32'h00123);
        release_switch();
        repeat (5) step();
        reset_dut();
        repeat (30) step();
        issue(0, 10'd0, 32'h0, 1, 10'd5, 1);
        repeat (2) step();

        // Randomized traffic over a small address pool.
        for (int i = 0; i < 11; i++) issue(1, pool[i], $urandom, 0, 10'd0, 0);
        prev_acc = 1'b0;
        for (int i = 0; i < 300; i++) begin
            wr  = $urandom_range(0, 1) == 1;
            rd  = $urandom_range(0, 1) == 1;
            acc = rd && !prev_acc;
            issue(wr, pool[$urandom_range(0, 11)], $urandom, rd, pool[$urandom_range(0, 10)], acc);
            prev_acc = acc;
        end
        repeat (5) step();
        check("drain", rq.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
